// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one downstream memory port between an ICache
// (line reads only) and a DCache (line reads or word stores).
//
// Handshake: each requester raises its valid with stable request fields and
// holds it until the matching ready pulses for one cycle. Downstream,
// mem_req is held with stable mem_addr/mem_we/mem_wdata until mem_ack
// pulses for one cycle. mem_rdata is only meaningful while mem_ack is high.
//
// Build option: define ARB_ROUND_ROBIN_EN to break simultaneous-request ties
// in favour of the requester not granted last. Leave it undefined for fixed
// DCache priority; the last-grant register then does not exist.
//
// dbg_state exposes the FSM state (0 IDLE, 1 GRANT_I, 2 GRANT_D, 3 RELEASE).
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128,
  parameter int WORD_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  // ICache port
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ready,
  output logic [LINE_W-1:0] i_rdata,
  // DCache port
  input  logic              d_valid,
  input  logic              d_for_store,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [WORD_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [LINE_W-1:0] d_rdata,
  // Downstream memory port
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [LINE_W-1:0] mem_rdata,
  // Debug view of the FSM state
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GRANT_I = 2'd1,
    S_GRANT_D = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [WORD_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic                pick_d;

`ifdef ARB_ROUND_ROBIN_EN
  // 0 = ICache was granted last, 1 = DCache was granted last.
  logic                last_d_q, last_d_d;

  // Tie goes to whoever was not served last; a lone request always wins.
  always_comb begin
    pick_d = d_valid;
    if (i_valid && d_valid) begin
      pick_d = ~last_d_q;
    end
  end
`else
  // Fixed priority: DCache wins whenever it is requesting.
  always_comb begin
    pick_d = d_valid;
  end
`endif

  // Next-state logic; request fields are captured only on the IDLE->GRANT
  // edge so the downstream request stays stable whatever the caches do.
  always_comb begin
    state_d     = state_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef ARB_ROUND_ROBIN_EN
    last_d_d    = last_d_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (i_valid || d_valid) begin
          if (pick_d) begin
            state_d     = S_GRANT_D;
            mem_addr_d  = d_addr;
            mem_we_d    = d_for_store;
            mem_wdata_d = d_for_store ? d_wdata : '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_d    = 1'b1;
`endif
          end else begin
            state_d     = S_GRANT_I;
            mem_addr_d  = i_addr;
            mem_we_d    = 1'b0;
            mem_wdata_d = '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d_d    = 1'b0;
`endif
          end
        end
      end
      S_GRANT_I, S_GRANT_D: begin
        if (mem_ack) begin
          state_d = S_RELEASE;
        end
      end
      // One dead cycle lets the served requester drop its valid before
      // arbitration looks again.
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and latched downstream request fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

`ifdef ARB_ROUND_ROBIN_EN
  // Last-grant register, reset to ICache.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_d_q <= 1'b0;
    end else begin
      last_d_q <= last_d_d;
    end
  end
`endif

  // Completion pulses follow mem_ack directly; acks outside GRANT are dropped.
  always_comb begin
    mem_req   = (state_q == S_GRANT_I) || (state_q == S_GRANT_D);
    mem_we    = mem_we_q;
    mem_addr  = mem_addr_q;
    mem_wdata = mem_wdata_q;
    i_ready   = mem_ack && (state_q == S_GRANT_I);
    d_ready   = mem_ack && (state_q == S_GRANT_D);
    i_rdata   = i_ready ? mem_rdata : '0;
    // A store returns no line, so the DCache sees zero data on its ready.
    d_rdata   = (d_ready && !mem_we_q) ? mem_rdata : '0;
    dbg_state = state_q;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a table of single transactions with
// hand-computed expectations, then sequences for address hold, simultaneous
// requests, reset during a grant and a spurious mem_ack.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int LW = 128;
  localparam int WW = 32;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT_I = 2'd1;
  localparam logic [1:0] ST_GRANT_D = 2'd2;
  localparam logic [1:0] ST_RELEASE = 2'd3;

  logic          clk;
  logic          rst;
  logic          i_valid;
  logic [AW-1:0] i_addr;
  logic          i_ready;
  logic [LW-1:0] i_rdata;
  logic          d_valid;
  logic          d_for_store;
  logic [AW-1:0] d_addr;
  logic [WW-1:0] d_wdata;
  logic          d_ready;
  logic [LW-1:0] d_rdata;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [WW-1:0] mem_wdata;
  logic          mem_ack;
  logic [LW-1:0] mem_rdata;
  logic [1:0]    dbg_state;

  mem_port_arbiter #(.ADDR_W(AW), .LINE_W(LW), .WORD_W(WW)) dut (
    .clk(clk), .rst(rst),
    .i_valid(i_valid), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
    .d_valid(d_valid), .d_for_store(d_for_store), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int errors;
  int i_pulses;
  int d_pulses;

  // Count ready pulses as the arbiter's clock sees them.
  always @(posedge clk) begin
    if (i_ready) i_pulses++;
    if (d_ready) d_pulses++;
  end

  typedef struct {
    logic          is_d;
    logic          store;
    logic [AW-1:0] addr;
    logic [WW-1:0] wdata;
    logic [LW-1:0] rdata;
    int            ack_dly;
    logic          exp_we;
    logic [WW-1:0] exp_wdata;
    logic [LW-1:0] exp_rdata;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic wait_req(input int budget, input string name);
    int n;
    n = 0;
    while (!mem_req && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_req_timeout"}, LW'(mem_req), LW'(1'b1));
  endtask

  task automatic clear_inputs();
    i_valid     = 1'b0;
    i_addr      = '0;
    d_valid     = 1'b0;
    d_for_store = 1'b0;
    d_addr      = '0;
    d_wdata     = '0;
    mem_ack     = 1'b0;
    mem_rdata   = '0;
  endtask

  // Drive one table entry from request to back in IDLE.
  task automatic run_vec(input int k);
    vec_t v;
    int   ip0, dp0;
    v   = vecs[k];
    ip0 = i_pulses;
    dp0 = d_pulses;
    @(negedge clk);
    if (v.is_d) begin
      d_valid     = 1'b1;
      d_for_store = v.store;
      d_addr      = v.addr;
      d_wdata     = v.wdata;
    end else begin
      i_valid = 1'b1;
      i_addr  = v.addr;
      d_wdata = v.wdata;
    end
    #1;
    chk($sformatf("v%0d_req_before_edge", k), LW'(mem_req), LW'(1'b0));
    @(negedge clk);
    chk($sformatf("v%0d_req", k), LW'(mem_req), LW'(1'b1));
    chk($sformatf("v%0d_state", k), LW'(dbg_state), LW'(v.is_d ? ST_GRANT_D : ST_GRANT_I));
    chk($sformatf("v%0d_addr", k), LW'(mem_addr), LW'(v.addr));
    chk($sformatf("v%0d_we", k), LW'(mem_we), LW'(v.exp_we));
    chk($sformatf("v%0d_wdata", k), LW'(mem_wdata), LW'(v.exp_wdata));
    for (int c = 1; c < v.ack_dly; c++) begin
      @(negedge clk);
      chk($sformatf("v%0d_req_hold%0d", k, c), LW'(mem_req), LW'(1'b1));
      chk($sformatf("v%0d_addr_hold%0d", k, c), LW'(mem_addr), LW'(v.addr));
    end
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = v.rdata;
    #1;
    chk($sformatf("v%0d_i_ready", k), LW'(i_ready), LW'(!v.is_d));
    chk($sformatf("v%0d_d_ready", k), LW'(d_ready), LW'(v.is_d));
    chk($sformatf("v%0d_i_rdata", k), i_rdata, v.is_d ? '0 : v.exp_rdata);
    chk($sformatf("v%0d_d_rdata", k), d_rdata, v.is_d ? v.exp_rdata : '0);
    @(negedge clk);
    clear_inputs();
    #1;
    chk($sformatf("v%0d_release", k), LW'(dbg_state), LW'(ST_RELEASE));
    chk($sformatf("v%0d_release_req", k), LW'(mem_req), LW'(1'b0));
    @(negedge clk);
    chk($sformatf("v%0d_idle", k), LW'(dbg_state), LW'(ST_IDLE));
    chk($sformatf("v%0d_i_pulses", k), LW'(i_pulses - ip0), LW'(v.is_d ? 0 : 1));
    chk($sformatf("v%0d_d_pulses", k), LW'(d_pulses - dp0), LW'(v.is_d ? 1 : 0));
  endtask

  logic          first_d;
  logic [LW-1:0] line_a;
  logic [LW-1:0] line_b;
  int            ip0, dp0;

  initial begin
    checks   = 0;
    errors   = 0;
    i_pulses = 0;
    d_pulses = 0;
    line_a   = {32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};
    line_b   = {32'hA5A5A5A5, 32'h0F0F0F0F, 32'hF0F0F0F0, 32'h5A5A5A5A};

    //        is_d  store addr          wdata         rdata   dly we    exp_wdata     exp_rdata
    vecs[0] = '{1'b0, 1'b0, 32'h1C000010, 32'h00000000, line_a, 3, 1'b0, 32'h00000000, line_a};
    vecs[1] = '{1'b1, 1'b1, 32'h00001004, 32'hDEADBEEF, line_b, 1, 1'b1, 32'hDEADBEEF, '0};
    vecs[2] = '{1'b0, 1'b0, 32'h1C000020, 32'h12345678, line_b, 2, 1'b0, 32'h00000000, line_b};
    vecs[3] = '{1'b1, 1'b0, 32'h00002000, 32'hCAFEF00D, line_a, 1, 1'b0, 32'h00000000, line_a};

    // Reset state
    rst = 1'b1;
    clear_inputs();
    #1;
    chk("rst_state", LW'(dbg_state), LW'(ST_IDLE));
    chk("rst_req", LW'(mem_req), LW'(1'b0));
    chk("rst_we", LW'(mem_we), LW'(1'b0));
    chk("rst_addr", LW'(mem_addr), LW'(0));
    chk("rst_wdata", LW'(mem_wdata), LW'(0));
    chk("rst_i_ready", LW'(i_ready), LW'(1'b0));
    chk("rst_d_ready", LW'(d_ready), LW'(1'b0));
    @(negedge clk);
    rst = 1'b0;

    // Table-driven single transactions
    for (int k = 0; k < 4; k++) begin
      run_vec(k);
    end

    // DCache read whose inputs change while granted: latched fields hold
    @(negedge clk);
    d_valid     = 1'b1;
    d_for_store = 1'b0;
    d_addr      = 32'h00003000;
    d_wdata     = 32'h0;
    @(negedge clk);
    chk("hold_state", LW'(dbg_state), LW'(ST_GRANT_D));
    d_addr      = 32'hFFFF0000;
    d_for_store = 1'b1;
    d_wdata     = 32'h00000055;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      chk($sformatf("hold_addr%0d", c), LW'(mem_addr), LW'(32'h00003000));
      chk($sformatf("hold_we%0d", c), LW'(mem_we), LW'(1'b0));
      chk($sformatf("hold_wdata%0d", c), LW'(mem_wdata), LW'(0));
    end
    mem_ack   = 1'b1;
    mem_rdata = line_b;
    #1;
    chk("hold_d_rdata", d_rdata, line_b);
    @(negedge clk);
    clear_inputs();
    chk("hold_release_addr", LW'(mem_addr), LW'(32'h00003000));
    @(negedge clk);

    // Simultaneous requests, both held; DCache was granted last
`ifdef ARB_ROUND_ROBIN_EN
    first_d = 1'b0;
`else
    first_d = 1'b1;
`endif
    ip0 = i_pulses;
    dp0 = d_pulses;
    @(negedge clk);
    i_valid     = 1'b1;
    i_addr      = 32'h1C000040;
    d_valid     = 1'b1;
    d_for_store = 1'b0;
    d_addr      = 32'h00004000;
    @(negedge clk);
    chk("tie1_state", LW'(dbg_state), LW'(first_d ? ST_GRANT_D : ST_GRANT_I));
    chk("tie1_addr", LW'(mem_addr), LW'(first_d ? 32'h00004000 : 32'h1C000040));
    mem_ack   = 1'b1;
    mem_rdata = line_a;
    #1;
    chk("tie1_i_ready", LW'(i_ready), LW'(!first_d));
    chk("tie1_d_ready", LW'(d_ready), LW'(first_d));
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    if (first_d) d_valid = 1'b0;
    else         i_valid = 1'b0;
    #1;
    chk("tie_release", LW'(dbg_state), LW'(ST_RELEASE));
    chk("tie_release_req", LW'(mem_req), LW'(1'b0));
    @(negedge clk);
    wait_req(4, "tie2");
    chk("tie2_state", LW'(dbg_state), LW'(first_d ? ST_GRANT_I : ST_GRANT_D));
    chk("tie2_addr", LW'(mem_addr), LW'(first_d ? 32'h1C000040 : 32'h00004000));
    chk("tie2_we", LW'(mem_we), LW'(1'b0));
    mem_ack   = 1'b1;
    mem_rdata = line_b;
    #1;
    chk("tie2_i_rdata", i_rdata, first_d ? line_b : '0);
    chk("tie2_d_rdata", d_rdata, first_d ? '0 : line_b);
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    chk("tie_idle", LW'(dbg_state), LW'(ST_IDLE));
    chk("tie_i_pulses", LW'(i_pulses - ip0), LW'(1));
    chk("tie_d_pulses", LW'(d_pulses - dp0), LW'(1));

    // Reset while GRANT_D waits for mem_ack
    dp0 = d_pulses;
    @(negedge clk);
    d_valid     = 1'b1;
    d_for_store = 1'b1;
    d_addr      = 32'h00005000;
    d_wdata     = 32'h00000011;
    @(negedge clk);
    chk("rstg_state", LW'(dbg_state), LW'(ST_GRANT_D));
    chk("rstg_req", LW'(mem_req), LW'(1'b1));
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rstg_req_drop", LW'(mem_req), LW'(1'b0));
    chk("rstg_state_idle", LW'(dbg_state), LW'(ST_IDLE));
    chk("rstg_addr", LW'(mem_addr), LW'(0));
    chk("rstg_we", LW'(mem_we), LW'(1'b0));
    d_valid = 1'b0;
    @(negedge clk);
    mem_ack = 1'b1;
    #1;
    chk("rstg_d_ready", LW'(d_ready), LW'(1'b0));
    mem_ack = 1'b0;
    rst     = 1'b0;
    @(negedge clk);
    chk("rstg_after_state", LW'(dbg_state), LW'(ST_IDLE));
    chk("rstg_after_req", LW'(mem_req), LW'(1'b0));
    chk("rstg_d_pulses", LW'(d_pulses - dp0), LW'(0));

    // Spurious mem_ack in IDLE
    ip0 = i_pulses;
    dp0 = d_pulses;
    @(negedge clk);
    mem_ack   = 1'b1;
    mem_rdata = line_a;
    #1;
    chk("spur_i_ready", LW'(i_ready), LW'(1'b0));
    chk("spur_d_ready", LW'(d_ready), LW'(1'b0));
    chk("spur_i_rdata", i_rdata, '0);
    chk("spur_d_rdata", d_rdata, '0);
    @(negedge clk);
    mem_ack   = 1'b0;
    mem_rdata = '0;
    chk("spur_state", LW'(dbg_state), LW'(ST_IDLE));
    chk("spur_req", LW'(mem_req), LW'(1'b0));
    @(negedge clk);
    chk("spur_pulses", LW'((i_pulses - ip0) + (d_pulses - dp0)), LW'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound in case a sequence stalls.
  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

Interface
REQ-001 The block SHALL have parameter ADDR_W, default 32, meaning the byte address width.
REQ-002 The block SHALL have parameter LINE_W, default 128, meaning the cache line and refill data width.
REQ-003 The block SHALL have parameter WORD_W, default 32, meaning the store data width.
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 Port i_valid, input, 1 bit: ICache line-read request, held high until i_ready.
REQ-007 Port i_addr, input, ADDR_W bits: ICache request address.
REQ-008 Port i_ready, output, 1 bit: one-cycle ICache completion pulse.
REQ-009 Port i_rdata, output, LINE_W bits: refill line for ICache.
REQ-010 Port d_valid, input, 1 bit: DCache request, held high until d_ready.
REQ-011 Port d_for_store, input, 1 bit: 1 means word store, 0 means line read.
REQ-012 Port d_addr, input, ADDR_W bits: DCache request address.
REQ-013 Port d_wdata, input, WORD_W bits: DCache store data.
REQ-014 Port d_ready, output, 1 bit: one-cycle DCache completion pulse.
REQ-015 Port d_rdata, output, LINE_W bits: refill line for DCache.
REQ-016 Port mem_req, output, 1 bit: downstream request, held until mem_ack.
REQ-017 Port mem_we, output, 1 bit: downstream write enable.
REQ-018 Port mem_addr, output, ADDR_W bits: downstream address.
REQ-019 Port mem_wdata, output, WORD_W bits: downstream store data.
REQ-020 Port mem_ack, input, 1 bit: downstream one-cycle completion pulse.
REQ-021 Port mem_rdata, input, LINE_W bits: downstream read line, valid while mem_ack is high.

Function
REQ-022 The FSM SHALL have the states IDLE, GRANT_I, GRANT_D and RELEASE.
- IDLE, no request pending: the FSM stays in IDLE.
- IDLE, request pending: the FSM goes to the winner's GRANT state on the next edge.
- On entry to a GRANT state, addr/we/wdata are latched from the winner into output registers.
REQ-023 mem_req SHALL be 1 exactly while in a GRANT state, first asserted one cycle after the winning valid is sampled.
REQ-024 mem_addr, mem_we and mem_wdata SHALL be held stable for the whole GRANT state, regardless of requester input changes.
REQ-025 On mem_ack, the FSM SHALL:
- pulse the granted requester's ready for that cycle only (combinational from mem_ack and the state);
- drive that requester's rdata from mem_rdata in the same cycle;
- move to RELEASE.
REQ-026 mem_we SHALL be 1 only for DCache stores; ICache grants SHALL always read.
REQ-027 RELEASE SHALL last exactly one cycle and then return to IDLE, so a requester's dropped valid is never re-granted.
REQ-028 i_rdata and d_rdata SHALL equal mem_rdata gated by their ready, and be zero otherwise.
REQ-029 Arbitration priority without ARB_ROUND_ROBIN_EN: DCache SHALL win when both valids are high in IDLE.
REQ-030 A valid that rises while another transaction is granted SHALL be held pending and not be lost.
REQ-031 mem_ack in IDLE or RELEASE SHALL be ignored, with no ready pulse and no state change.
REQ-032 At most one transaction SHALL be outstanding downstream at any time.

Reset
REQ-033 Reset SHALL force, immediately and asynchronously:
- state IDLE;
- mem_req, mem_we, i_ready and d_ready to 0;
- mem_addr, mem_wdata, i_rdata and d_rdata to 0;
- the last-grant register to 0 (ICache).
REQ-034 Reset mid-GRANT SHALL abandon the transaction with no ready pulse; requesters re-request after reset.

Configuration
REQ-035 Macro ARB_ROUND_ROBIN_EN selects the tie-break rule.
- Defined: on a simultaneous request, the requester not granted last SHALL win; the last-grant register updates on every grant.
- Undefined: fixed DCache priority, and the last-grant register SHALL be absent.

Verification
REQ-036 ICache alone: i_valid=1, i_addr=0x1C000010, mem_ack 3 cycles after mem_req.
- mem_req rises 1 cycle after i_valid, with mem_addr=0x1C000010 and mem_we=0.
- i_ready pulses once, with i_rdata=mem_rdata.
REQ-037 DCache store: d_valid=1, d_for_store=1, d_addr=0x00001004, d_wdata=0xDEADBEEF.
- Required: mem_we=1, mem_addr=0x00001004, mem_wdata=0xDEADBEEF.
- d_ready pulses once and d_rdata=0.
REQ-038 Simultaneous i_valid/d_valid in the same cycle, both held:
- Fixed build: DCache is served, then ICache after RELEASE.
- ARB_ROUND_ROBIN_EN build: with last grant DCache, ICache is served first.
REQ-039 Assert rst while in GRANT_D before mem_ack:
- mem_req drops immediately;
- no d_ready pulse;
- state is IDLE after rst deasserts.
REQ-040 Spurious mem_ack in IDLE: no ready pulse and mem_req stays 0.
REQ-041 d_addr changes while in GRANT_D: mem_addr is unchanged until RELEASE.
